// File: rtl/aes_xts_sector_driver.sv
// aes_xts_sector_driver: sequences key load, tweak/block-number programming and
// one sector of 128-bit blocks through the AES-XTS block engine, returning
// results upstream over valid/ready. Optional macro AES_XTS_DRV_TIMEOUT_EN adds a
// watchdog on keys-ready and engine-busy waits that raises a sticky outError.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | no keys loaded; only a key load is accepted
// S_KEY_WR    | key write strobe to engine
// S_KEY_WAIT  | waiting for engine keys-ready
// S_READY     | keys loaded; accepts key reload or sector start
// S_TWEAK_WR  | tweak (sector number) write strobe
// S_BLK_WAIT  | offering outBlkReady for the next upstream block
// S_NR_WR     | block-number write strobe
// S_DATA_WR   | data write strobe, latency counter loaded
// S_DATA_WAIT | minimum latency countdown, then wait for engine not busy
// S_RES_HOLD  | result held until downstream accepts it
module aes_xts_sector_driver #(
    parameter int unsigned BLOCKS_PER_SECTOR = 32,
    parameter int unsigned MIN_LATENCY       = 5,
    parameter int unsigned KEY_TIMEOUT       = 64
) (
    input  logic         inClk,
    input  logic         inRst,
    input  logic         inAesMode,
    input  logic         inKeyLoad,
    input  logic [511:0] inKeyData,
    input  logic         inSectorStart,
    input  logic [127:0] inSectorNr,
    input  logic         inBlkValid,
    input  logic [127:0] inBlkData,
    output logic         outBlkReady,
    output logic         outResValid,
    output logic [127:0] outResData,
    input  logic         inResReady,
    output logic         outSectorDone,
    output logic         outIdle,
    output logic         outEngAesMode,
    output logic         outEngKeyWr,
    output logic         outEngDataWr,
    output logic         outEngTweakValueWr,
    output logic         outEngBlockNrWr,
    output logic [511:0] outEngKeyData,
    output logic [127:0] outEngDataData,
    output logic [127:0] outEngTweakValueData,
    output logic [127:0] outEngBlockNrData,
    input  logic [127:0] inEngData,
    input  logic         inEngKeysReady,
    input  logic         inEngBusy,
    output logic         outError
);

    localparam int unsigned      LAT_W    = $clog2(MIN_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MIN_LATENCY);
    localparam logic [7:0]       LAST_BLK = 8'(BLOCKS_PER_SECTOR - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_KEY_WR, S_KEY_WAIT, S_READY, S_TWEAK_WR,
        S_BLK_WAIT, S_NR_WR, S_DATA_WR, S_DATA_WAIT, S_RES_HOLD
    } state_t;

    state_t             state_q;
    logic               keys_loaded_q;
    logic [7:0]         blk_cnt_q;
    logic [7:0]         blk_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [LAT_W-1:0]   lat_cnt_d;
    logic               mode_q;
    logic               key_wr_q;
    logic               tweak_wr_q;
    logic               nr_wr_q;
    logic               data_wr_q;
    logic [511:0]       key_data_q;
    logic [127:0]       data_data_q;
    logic [127:0]       tweak_data_q;
    logic               blk_rdy_q;
    logic               res_valid_q;
    logic [127:0]       res_data_q;
    logic               done_q;
    logic               wd_fire;

    assign blk_cnt_d = blk_cnt_q + 8'd1;
    assign lat_cnt_d = lat_cnt_q - LAT_W'(1);

`ifdef AES_XTS_DRV_TIMEOUT_EN
    localparam int unsigned     WD_W     = $clog2(KEY_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(KEY_TIMEOUT - 1);

    logic [WD_W-1:0] wdog_q;
    logic            error_q;
    logic            waiting;

    // Only open-ended waits on the engine are watched; the fixed latency countdown is not.
    assign waiting = ((state_q == S_KEY_WAIT) && !inEngKeysReady) ||
                     ((state_q == S_DATA_WAIT) && (lat_cnt_q == '0) && inEngBusy);
    assign wd_fire = waiting && (wdog_q == WD_LIMIT);
    assign outError = error_q;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= waiting ? wdog_q + WD_W'(1) : '0;
            error_q <= error_q | wd_fire;
        end
    end
`else
    logic unused_key_timeout;

    assign unused_key_timeout = (KEY_TIMEOUT == 0);
    assign wd_fire  = 1'b0;
    assign outError = 1'b0;
`endif

    // Main sequencer: all engine strobes and upstream/downstream handshakes are registered here.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q       <= S_IDLE;
            keys_loaded_q <= 1'b0;
            blk_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            mode_q        <= 1'b0;
            key_wr_q      <= 1'b0;
            tweak_wr_q    <= 1'b0;
            nr_wr_q       <= 1'b0;
            data_wr_q     <= 1'b0;
            key_data_q    <= '0;
            data_data_q   <= '0;
            tweak_data_q  <= '0;
            blk_rdy_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            key_wr_q   <= 1'b0;
            tweak_wr_q <= 1'b0;
            nr_wr_q    <= 1'b0;
            data_wr_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE, S_READY: begin
                    if (inKeyLoad) begin
                        key_data_q <= inKeyData;
                        key_wr_q   <= 1'b1;
                        state_q    <= S_KEY_WR;
                    end else if (inSectorStart && keys_loaded_q) begin
                        mode_q       <= inAesMode;
                        tweak_data_q <= inSectorNr;
                        blk_cnt_q    <= '0;
                        tweak_wr_q   <= 1'b1;
                        state_q      <= S_TWEAK_WR;
                    end
                end
                S_KEY_WR: state_q <= S_KEY_WAIT;
                S_KEY_WAIT: begin
                    if (inEngKeysReady) begin
                        keys_loaded_q <= 1'b1;
                        state_q       <= S_READY;
                    end else if (wd_fire) begin
                        keys_loaded_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                S_TWEAK_WR: begin
                    blk_rdy_q <= 1'b1;
                    state_q   <= S_BLK_WAIT;
                end
                S_BLK_WAIT: begin
                    if (inBlkValid) begin
                        blk_rdy_q   <= 1'b0;
                        data_data_q <= inBlkData;
                        nr_wr_q     <= 1'b1;
                        state_q     <= S_NR_WR;
                    end
                end
                S_NR_WR: begin
                    data_wr_q <= 1'b1;
                    state_q   <= S_DATA_WR;
                end
                S_DATA_WR: begin
                    lat_cnt_q <= LAT_LOAD;
                    state_q   <= S_DATA_WAIT;
                end
                S_DATA_WAIT: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_d;
                    end else if (!inEngBusy) begin
                        res_data_q  <= inEngData;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RES_HOLD;
                    end else if (wd_fire) begin
                        keys_loaded_q <= 1'b0;
                        res_valid_q   <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                S_RES_HOLD: begin
                    if (inResReady) begin
                        res_valid_q <= 1'b0;
                        if (blk_cnt_q == LAST_BLK) begin
                            done_q  <= 1'b1;
                            state_q <= S_READY;
                        end else begin
                            blk_cnt_q <= blk_cnt_d;
                            blk_rdy_q <= 1'b1;
                            state_q   <= S_BLK_WAIT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign outIdle              = (state_q == S_IDLE) || (state_q == S_READY);
    assign outBlkReady          = blk_rdy_q;
    assign outResValid          = res_valid_q;
    assign outResData           = res_data_q;
    assign outSectorDone        = done_q;
    assign outEngAesMode        = mode_q;
    assign outEngKeyWr          = key_wr_q;
    assign outEngTweakValueWr   = tweak_wr_q;
    assign outEngBlockNrWr      = nr_wr_q;
    assign outEngDataWr         = data_wr_q;
    assign outEngKeyData        = key_data_q;
    assign outEngDataData       = data_data_q;
    assign outEngTweakValueData = tweak_data_q;
    assign outEngBlockNrData    = {120'd0, blk_cnt_q};

endmodule
